// File: rtl/dpram_stream_reader.sv
// Burst reader that streams a run of words from a dual-port RAM's registered read port through a 2-entry skid FIFO.
// Optional feature: define STREAM_READER_LAST_EN to add out_last, which marks the final word of each burst.
module dpram_stream_reader #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_wren,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef STREAM_READER_LAST_EN
    output logic              out_last,
`endif
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AWIDTH:0]   ONE_CNT  = 1;
    localparam logic [AWIDTH-1:0] ONE_ADDR = 1;

    logic [1:0]        r_state;
    logic [AWIDTH:0]   r_num;
    logic [AWIDTH:0]   r_issued;
    logic [AWIDTH:0]   r_sent;
    logic [AWIDTH-1:0] r_next_addr;
    logic [AWIDTH-1:0] r_last_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic [DWIDTH-1:0] r_mem [2];
    logic              r_last_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_issue_last;
    logic [AWIDTH:0]   w_sent_next;
    logic              w_finish;

    // Stream handshake: a word moves when out_valid && out_ready at a rising edge;
    // out_valid comes only from FIFO occupancy, so it never depends on out_ready.
    assign w_accept     = start && (r_state == S_IDLE) && !r_done;
    assign w_push       = r_inflight;
    assign w_pop        = (r_count != 2'd0) && out_ready;
    // Credit counts the word popped this cycle as already gone, which is what keeps 1 word/cycle.
    assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_RUN) && (r_issued != r_num) && (w_occ < 3'd2);
    assign w_issue_last = (r_issued + ONE_CNT) == r_num;
    assign w_sent_next  = r_sent + {{AWIDTH{1'b0}}, w_pop};
    assign w_finish     = (r_state == S_DRAIN) && (w_sent_next == r_num);

    assign busy      = (r_state != S_IDLE) || r_done;
    assign done      = r_done;
    assign ram_addr  = w_issue ? r_next_addr : r_last_addr;
    assign ram_wren  = 1'b0;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rptr];
    assign dbg_state = r_state;
`ifdef STREAM_READER_LAST_EN
    assign out_last  = out_valid && r_last_mem[r_rptr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_num           <= '0;
            r_issued        <= '0;
            r_sent          <= '0;
            r_next_addr     <= '0;
            r_last_addr     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= w_finish;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            r_sent          <= w_sent_next;
            if (w_issue) begin
                r_issued    <= r_issued + ONE_CNT;
                r_next_addr <= r_next_addr + ONE_ADDR;
                r_last_addr <= r_next_addr;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num       <= num_words;
                        r_issued    <= '0;
                        r_sent      <= '0;
                        r_next_addr <= base_addr;
                        r_state     <= (num_words == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_finish) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data for an address issued last cycle is on ram_rdata now and lands in the FIFO at this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0]      <= '0;
            r_mem[1]      <= '0;
            r_last_mem[0] <= 1'b0;
            r_last_mem[1] <= 1'b0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]      <= ram_rdata;
                r_last_mem[r_wptr] <= r_inflight_last;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench for dpram_stream_reader: a RAM model preloaded with ram[i]=i plus directed bursts.
module tb_dpram_stream_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    dbg_state;
`ifdef STREAM_READER_LAST_EN
  logic          out_last;
  logic          exp_last_q[$];
`endif

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int xfer_count = 0;
  bit rand_ready = 0;

  dpram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef STREAM_READER_LAST_EN
    .out_last(out_last),
`endif
    .dbg_state(dbg_state)
  );

  // ---- clock / reset / RAM model ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
  end

  always @(posedge clk) ram_rdata <= ram[ram_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---- checking helper ----
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---- ready driver for the back-pressure test ----
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---- monitor: pops the scoreboard on every transfer, checks stall stability ----
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_w;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_hold", 64'(out_valid), 64'd1);
          check("stall_data_hold", 64'(out_data), 64'(prev_data));
        end
        if (out_valid && out_ready) begin
          xfer_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("stream_data", 64'(out_data), 64'(exp_w));
`ifdef STREAM_READER_LAST_EN
            check("out_last", 64'(out_last), 64'(exp_last_q.pop_front()));
`endif
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // ---- driver: issue one burst, push expectations, time the response ----
  task automatic push_expected(input int base, input int num);
    for (int i = 0; i < num; i++) begin
      exp_q.push_back(DW'((base + i) % DEPTH));
`ifdef STREAM_READER_LAST_EN
      exp_last_q.push_back(i == num - 1);
`endif
    end
  endtask

  task automatic run_burst(input int base, input int num, input int ignore_k,
                           output int first_k, output int done_k,
                           output int busy_n, output int valid_n);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    num_words = (AW+1)'(num);
    push_expected(base, num);
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    first_k = -1;
    done_k  = -1;
    busy_n  = 0;
    valid_n = 0;
    for (int k = 0; k < 5000 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == ignore_k) begin
        start     = 1'b1;
        base_addr = AW'(7);
        num_words = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end
      if (out_valid && first_k < 0) first_k = k;
      if (out_valid) valid_n++;
      if (busy) busy_n++;
      if (done) done_k = k;
    end
    if (done_k < 0) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---- test sequence ----
  initial begin
    int fk, dk, bn, vn, x0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wren", 64'(ram_wren), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // base 4, 8 words, ready high: valid at k=2, 8 back-to-back, done at k=10
    run_burst(4, 8, -1, fk, dk, bn, vn);
    check("a_first_valid", 64'(fk), 64'd2);
    check("a_done_k", 64'(dk), 64'd10);
    check("a_busy_cycles", 64'(bn), 64'd11);
    check("a_valid_cycles", 64'(vn), 64'd8);

    // address wrap 1020..1023,0..3
    run_burst(1020, 8, -1, fk, dk, bn, vn);
    check("b_first_valid", 64'(fk), 64'd2);
    check("b_done_k", 64'(dk), 64'd10);

    // zero-length burst: no data, done at k=1, busy two cycles
    run_burst(9, 0, -1, fk, dk, bn, vn);
    check("z_no_valid", 64'(vn), 64'd0);
    check("z_done_k", 64'(dk), 64'd1);
    check("z_busy_cycles", 64'(bn), 64'd2);

    // 16 words under random back-pressure
    rand_ready = 1'b1;
    run_burst(100, 16, -1, fk, dk, bn, vn);
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    check("r_valid_at_least", 64'(vn >= 16), 64'd1);

    // start while busy (mid-burst and in the done cycle) must be ignored
    run_burst(200, 5, 2, fk, dk, bn, vn);
    check("i_done_k", 64'(dk), 64'd7);
    check("i_busy_cycles", 64'(bn), 64'd8);
    run_burst(300, 5, 7, fk, dk, bn, vn);
    check("i2_done_k", 64'(dk), 64'd7);

    // full-length burst 2^AWIDTH words starting mid-array
    run_burst(512, 1024, -1, fk, dk, bn, vn);
    check("f_done_k", 64'(dk), 64'd1026);
    check("f_valid_cycles", 64'(vn), 64'd1024);

    // reset after 3 words of a 10-word burst
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(50);
    num_words = (AW+1)'(10);
    push_expected(50, 10);
    x0 = xfer_count;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 100 && xfer_count < x0 + 3; k++) begin
      @(negedge clk);
      #1;
    end
    check("abort_three_words", 64'(xfer_count - x0), 64'd3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
`ifdef STREAM_READER_LAST_EN
    exp_last_q.delete();
`endif
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_ram_addr", 64'(ram_addr), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
      check("abort_idle_valid", 64'(out_valid), 64'd0);
    end
    run_burst(0, 2, -1, fk, dk, bn, vn);
    check("post_first_valid", 64'(fk), 64'd2);
    check("post_done_k", 64'(dk), 64'd4);
    check("post_valid_cycles", 64'(vn), 64'd2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
